// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with a pedestrian crossing on the side-road phase.
// Drives one external timer: each phase issues a one-cycle t_start with the phase
// length, then waits for t_done before moving on. Main green is extended for as long
// as there is no side-road demand.
module traffic_light_ctrl #(
   parameter int unsigned MAIN_GREEN_LEN = 20,
   parameter int unsigned SIDE_GREEN_LEN = 10,
   parameter int unsigned YELLOW_LEN     = 4,
   parameter int unsigned ALLRED_LEN     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       car_side,
   input  logic       ped_req,
   input  logic       t_done,
   input  logic       t_flicker,
   output logic       t_start,
   output logic [4:0] t_length,
   output logic       main_r,
   output logic       main_y,
   output logic       main_g,
   output logic       side_r,
   output logic       side_y,
   output logic       side_g,
   output logic       walk,
   output logic [2:0] state
);

   localparam logic [2:0] AR_A = 3'd0;  // all red after main
   localparam logic [2:0] MG   = 3'd1;
   localparam logic [2:0] MY   = 3'd2;
   localparam logic [2:0] AR_B = 3'd3;  // all red after side
   localparam logic [2:0] SG   = 3'd4;
   localparam logic [2:0] SY   = 3'd5;

   localparam logic [4:0] MainGreenLen = 5'(MAIN_GREEN_LEN);
   localparam logic [4:0] SideGreenLen = 5'(SIDE_GREEN_LEN);
   localparam logic [4:0] YellowLen    = 5'(YELLOW_LEN);
   localparam logic [4:0] AllredLen    = 5'(ALLRED_LEN);

   logic [2:0] state_q, state_d;
   logic       first_q, first_d;
   logic       ped_pending_q, ped_pending_d;
   logic       walk_active_q, walk_active_d;
   logic       blk_q, blk_d;

   logic advance;
   logic demand;
   logic enter_sg;
   logic leave_sg;

   // A stale t_done from the previous phase is ignored in the first cycle of a phase.
   assign advance  = ~first_q & t_done;
   assign demand   = car_side | ped_pending_q | ped_req;
   assign enter_sg = advance & (state_q == AR_A);
   assign leave_sg = advance & (state_q == SG);

   // Phase sequencing; main green with no demand re-enters itself to restart the timer.
   always_comb begin
      state_d = state_q;
      first_d = 1'b0;
      if (advance) begin
         first_d = 1'b1;
         case (state_q)
            AR_B:    state_d = MG;
            MG:      state_d = demand ? MY : MG;
            MY:      state_d = AR_A;
            AR_A:    state_d = SG;
            SG:      state_d = SY;
            SY:      state_d = AR_B;
            default: state_d = AR_B;
         endcase
      end
   end

   // Pedestrian request latch, walk enable and walk blink next-state.
   always_comb begin
      // A request arriving on the SG entry edge must survive the clear.
      ped_pending_d = ped_req | (ped_pending_q & ~enter_sg);

      walk_active_d = walk_active_q;
      if (enter_sg) begin
         walk_active_d = ped_pending_q | ped_req;
      end else if (leave_sg) begin
         walk_active_d = 1'b0;
      end

      blk_d = t_flicker & ~blk_q;
   end

   // Controller state registers with synchronous reset into the all-red phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= AR_B;
         first_q       <= 1'b1;
         ped_pending_q <= 1'b0;
         walk_active_q <= 1'b0;
         blk_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         first_q       <= first_d;
         ped_pending_q <= ped_pending_d;
         walk_active_q <= walk_active_d;
         blk_q         <= blk_d;
      end
   end

   // Timer length decoded from the current phase.
   always_comb begin
      case (state_q)
         MG:      t_length = MainGreenLen;
         SG:      t_length = SideGreenLen;
         MY, SY:  t_length = YellowLen;
         default: t_length = AllredLen;
      endcase
   end

   assign t_start = first_q;
   assign state   = state_q;

   // Lamps are a pure decode of the phase, so exactly one lamp per road is lit.
   assign main_g = (state_q == MG);
   assign main_y = (state_q == MY);
   assign main_r = ~(main_g | main_y);
   assign side_g = (state_q == SG);
   assign side_y = (state_q == SY);
   assign side_r = ~(side_g | side_y);

   assign walk = walk_active_q & (state_q == SG) & ~(t_flicker & blk_q);

endmodule
